// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means cluster-assignment datapath.
package kmeans_pkg;

  localparam int unsigned CW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Distance as returned by the distance unit: Q is the more significant part.
  typedef struct packed {
    logic [DW_DEF-1:0] q;
    logic [DW_DEF-1:0] r;
  } dist_t;

endpackage

// File: rtl/centroid_regfile.sv
// K-entry centroid table: one write port, one combinational read port.
module centroid_regfile #(
  parameter int unsigned K  = 4,
  parameter int unsigned CW = 10,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [CW-1:0] wx,
  input  logic [CW-1:0] wy,
  input  logic [IW-1:0] ra,
  output logic [CW-1:0] rx,
  output logic [CW-1:0] ry
);

  logic [2*CW-1:0] mem [K];

  // Table storage; addresses beyond K-1 never match an entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < K; i++) begin
        if (we && (wa == IW'(i))) mem[i] <= {wx, wy};
      end
    end
  end

  // Read mux written as a match loop so an out-of-range index reads zero.
  always_comb begin
    rx = '0;
    ry = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (ra == IW'(i)) begin
        rx = mem[i][2*CW-1:CW];
        ry = mem[i][CW-1:0];
      end
    end
  end

endmodule

// File: rtl/nearest_centroid_select.sv
// Streams a point against every centroid through the external distance unit
// and reports the index and distance of the nearest one.
module nearest_centroid_select
  import kmeans_pkg::*;
#(
  parameter int unsigned K        = 4,
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned DIST_LAT = 2,
  localparam int unsigned IW      = $clog2(K)
) (
  input  logic          select_clk,
  input  logic          select_rst,
  input  logic          select_cent_we,
  input  logic [IW-1:0] select_cent_wa,
  input  logic [CW-1:0] select_cent_x,
  input  logic [CW-1:0] select_cent_y,
  input  logic          select_pt_valid,
  output logic          select_pt_ready,
  input  logic [CW-1:0] select_pt_x,
  input  logic [CW-1:0] select_pt_y,
  output logic [CW-1:0] select_X1,
  output logic [CW-1:0] select_Y1,
  output logic [CW-1:0] select_X2,
  output logic [CW-1:0] select_Y2,
  input  logic [DW-1:0] select_dist_q,
  input  logic [DW-1:0] select_dist_r,
  output logic          select_res_valid,
  input  logic          select_res_ready,
  output logic [IW-1:0] select_res_idx,
  output logic [DW-1:0] select_res_q,
  output logic [DW-1:0] select_res_r
);

  localparam state_t AFTER_ISSUE = (DIST_LAT == 0) ? ST_DONE : ST_DRAIN;

  state_t        state, state_nxt;
  logic [IW-1:0] k;
  logic [CW-1:0] pt_x, pt_y;
  logic [CW-1:0] x1_hold, y1_hold, x2_hold, y2_hold;
  logic [CW-1:0] cent_x, cent_y;
  logic          issuing, accept, last_issue;
  logic          exit_valid, take;
  logic [IW-1:0] exit_idx;
  logic [IW-1:0] best_idx;
  logic [DW-1:0] best_q, best_r;
  logic [2*DW-1:0] cand;

  assign issuing    = (state == ST_ISSUE);
  assign accept     = (state == ST_IDLE) && select_pt_valid;
  assign last_issue = issuing && (k == IW'(K - 1));

  // Ready is gated by reset so nothing is offered while reset is held.
  assign select_pt_ready = (state == ST_IDLE) && select_rst;

  centroid_regfile #(
    .K  (K),
    .CW (CW),
    .IW (IW)
  ) u_regfile (
    .clk   (select_clk),
    .rst_n (select_rst),
    .we    (select_cent_we && (state == ST_IDLE)),
    .wa    (select_cent_wa),
    .wx    (select_cent_x),
    .wy    (select_cent_y),
    .ra    (k),
    .rx    (cent_x),
    .ry    (cent_y)
  );

  // State register.
  always_ff @(posedge select_clk or negedge select_rst) begin
    if (!select_rst) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: if (last_issue) state_nxt = AFTER_ISSUE;
      ST_DRAIN: if (exit_valid && (exit_idx == IW'(K - 1))) state_nxt = ST_DONE;
      ST_DONE:  if (select_res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Point latch and centroid counter.
  always_ff @(posedge select_clk or negedge select_rst) begin
    if (!select_rst) begin
      pt_x <= '0;
      pt_y <= '0;
      k    <= '0;
    end else if (accept) begin
      pt_x <= select_pt_x;
      pt_y <= select_pt_y;
      k    <= '0;
    end else if (issuing) begin
      k <= k + IW'(1);
    end
  end

  // X/Y drive the live point/centroid during ISSUE, and replay the last
  // issued pair from these holding registers in every other state. Driving
  // the centroid combinationally is what lets a write in the accept cycle
  // reach the first issue cycle.
  always_ff @(posedge select_clk or negedge select_rst) begin
    if (!select_rst) begin
      x1_hold <= '0;
      y1_hold <= '0;
      x2_hold <= '0;
      y2_hold <= '0;
    end else if (issuing) begin
      x1_hold <= pt_x;
      y1_hold <= pt_y;
      x2_hold <= cent_x;
      y2_hold <= cent_y;
    end
  end

  assign select_X1 = issuing ? pt_x   : x1_hold;
  assign select_Y1 = issuing ? pt_y   : y1_hold;
  assign select_X2 = issuing ? cent_x : x2_hold;
  assign select_Y2 = issuing ? cent_y : y2_hold;

  // Tag pipeline aligning each centroid index with its returned distance.
  if (DIST_LAT == 0) begin : g_no_lat
    assign exit_valid = issuing;
    assign exit_idx   = k;
  end else begin : g_lat
    logic [DIST_LAT-1:0] tag_v;
    logic [IW-1:0]       tag_i [DIST_LAT];

    // Shift the (valid, index) tag one stage per cycle.
    always_ff @(posedge select_clk or negedge select_rst) begin
      if (!select_rst) begin
        tag_v <= '0;
        for (int unsigned i = 0; i < DIST_LAT; i++) tag_i[i] <= '0;
      end else begin
        tag_v[0] <= issuing;
        tag_i[0] <= k;
        for (int unsigned i = 1; i < DIST_LAT; i++) begin
          tag_v[i] <= tag_v[i-1];
          tag_i[i] <= tag_i[i-1];
        end
      end
    end

    assign exit_valid = tag_v[DIST_LAT-1];
    assign exit_idx   = tag_i[DIST_LAT-1];
  end

  // Q is the more significant half, so one wide unsigned compare orders {Q,R}.
  assign cand = {select_dist_q, select_dist_r};
  assign take = exit_valid &&
                ((exit_idx == '0) || (cand < {best_q, best_r}));

  // Best-so-far register; strict less-than keeps the lowest index on ties.
  always_ff @(posedge select_clk or negedge select_rst) begin
    if (!select_rst) begin
      best_idx <= '0;
      best_q   <= '0;
      best_r   <= '0;
    end else if (take) begin
      best_idx <= exit_idx;
      best_q   <= select_dist_q;
      best_r   <= select_dist_r;
    end
  end

  assign select_res_valid = (state == ST_DONE);
  assign select_res_idx   = best_idx;
  assign select_res_q     = best_q;
  assign select_res_r     = best_r;

endmodule

// File: tb/tb_nearest_centroid_select.sv
// Randomized and directed bench for nearest_centroid_select with a
// behavioural distance unit and a reference nearest-centroid model.
module tb_nearest_centroid_select;

  localparam int unsigned K  = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned DL = 2;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          select_rst = 1'b0;
  logic          select_cent_we = 1'b0;
  logic [IW-1:0] select_cent_wa = '0;
  logic [CW-1:0] select_cent_x = '0, select_cent_y = '0;
  logic          select_pt_valid = 1'b0;
  logic          select_pt_ready;
  logic [CW-1:0] select_pt_x = '0, select_pt_y = '0;
  logic [CW-1:0] select_X1, select_Y1, select_X2, select_Y2;
  logic [DW-1:0] select_dist_q, select_dist_r;
  logic          select_res_valid;
  logic          select_res_ready = 1'b0;
  logic [IW-1:0] select_res_idx;
  logic [DW-1:0] select_res_q, select_res_r;

  int n_checks = 0;
  int n_pass   = 0;
  int mcx [K];
  int mcy [K];

  always #5 clk = ~clk;

  nearest_centroid_select #(
    .K        (K),
    .CW       (CW),
    .DW       (DW),
    .DIST_LAT (DL)
  ) dut (
    .select_clk       (clk),
    .select_rst       (select_rst),
    .select_cent_we   (select_cent_we),
    .select_cent_wa   (select_cent_wa),
    .select_cent_x    (select_cent_x),
    .select_cent_y    (select_cent_y),
    .select_pt_valid  (select_pt_valid),
    .select_pt_ready  (select_pt_ready),
    .select_pt_x      (select_pt_x),
    .select_pt_y      (select_pt_y),
    .select_X1        (select_X1),
    .select_Y1        (select_Y1),
    .select_X2        (select_X2),
    .select_Y2        (select_Y2),
    .select_dist_q    (select_dist_q),
    .select_dist_r    (select_dist_r),
    .select_res_valid (select_res_valid),
    .select_res_ready (select_res_ready),
    .select_res_idx   (select_res_idx),
    .select_res_q     (select_res_q),
    .select_res_r     (select_res_r)
  );

  // Euclidean distance as {floor(sqrt(d2)), d2 - floor^2}.
  function automatic logic [63:0] dist_qr(input int x1, y1, x2, y2);
    int unsigned d2, s;
    d2 = int'((x1 - x2) * (x1 - x2) + (y1 - y2) * (y1 - y2));
    s  = 0;
    for (int b = 15; b >= 0; b--) begin
      if (((s | (32'd1 << b)) * (s | (32'd1 << b))) <= d2) s = s | (32'd1 << b);
    end
    return {s, d2 - s * s};
  endfunction

  // Behavioural distance unit: DL-cycle delay of the combinational result.
  logic [63:0] dpipe [DL] = '{default: '0};
  always @(posedge clk) begin
    dpipe[0] <= dist_qr(int'(select_X1), int'(select_Y1), int'(select_X2), int'(select_Y2));
    for (int i = 1; i < DL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign select_dist_q = dpipe[DL-1][63:32];
  assign select_dist_r = dpipe[DL-1][31:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: minimum {q,r} over the table, lowest index first on ties.
  task automatic ref_nearest(input int px, py, output int bi, output logic [63:0] bd);
    logic [63:0] d;
    bi = 0;
    bd = dist_qr(px, py, mcx[0], mcy[0]);
    for (int i = 1; i < K; i++) begin
      d = dist_qr(px, py, mcx[i], mcy[i]);
      if (d < bd) begin
        bi = i;
        bd = d;
      end
    end
  endtask

  task automatic load_cents(input int cx [K], input int cy [K]);
    for (int i = 0; i < K; i++) begin
      select_cent_we = 1'b1;
      select_cent_wa = IW'(i);
      select_cent_x  = CW'(cx[i]);
      select_cent_y  = CW'(cy[i]);
      mcx[i] = cx[i];
      mcy[i] = cy[i];
      @(posedge clk); #1;
    end
    select_cent_we = 1'b0;
  endtask

  // Offer one point, optionally poking the table at accept or while busy,
  // then check latency, result, backpressure stability and the handshake.
  task automatic run_point(input string tag, input int px, py, input int hold,
                           input bit poke_acc, input bit poke_busy,
                           input int pa, pwx, pwy);
    int          ei, edges;
    logic [63:0] ed;
    bit          seen;
    check({tag, "_rdy_idle"}, 64'(select_pt_ready), 64'd1);
    select_pt_x = CW'(px);
    select_pt_y = CW'(py);
    select_pt_valid = 1'b1;
    if (poke_acc) begin
      select_cent_we = 1'b1;
      select_cent_wa = IW'(pa);
      select_cent_x  = CW'(pwx);
      select_cent_y  = CW'(pwy);
      mcx[pa] = pwx;
      mcy[pa] = pwy;
    end
    ref_nearest(px, py, ei, ed);
    @(posedge clk); #1;
    select_pt_valid = 1'b0;
    select_cent_we  = 1'b0;
    check({tag, "_rdy_busy"}, 64'(select_pt_ready), 64'd0);
    if (poke_busy) begin
      select_cent_we = 1'b1;
      select_cent_wa = IW'(pa);
      select_cent_x  = CW'(pwx);
      select_cent_y  = CW'(pwy);
    end
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (select_res_valid) seen = 1'b1;
    end
    select_cent_we = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'(K + DL));
    check({tag, "_idx"}, 64'(select_res_idx), 64'(ei));
    check({tag, "_q"}, 64'(select_res_q), 64'(ed[63:32]));
    check({tag, "_r"}, 64'(select_res_r), 64'(ed[31:0]));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_bp_valid"}, 64'(select_res_valid), 64'd1);
      check({tag, "_bp_rdy"}, 64'(select_pt_ready), 64'd0);
      check({tag, "_bp_idx"}, 64'(select_res_idx), 64'(ei));
      check({tag, "_bp_q"}, 64'(select_res_q), 64'(ed[63:32]));
      check({tag, "_bp_r"}, 64'(select_res_r), 64'(ed[31:0]));
    end
    select_res_ready = 1'b1;
    @(posedge clk); #1;
    select_res_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(select_res_valid), 64'd0);
    check({tag, "_post_rdy"}, 64'(select_pt_ready), 64'd1);
  endtask

  initial begin
    int cx [K];
    int cy [K];

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 64'(select_pt_ready), 64'd0);
    check("rst_valid", 64'(select_res_valid), 64'd0);
    check("rst_xy", {16'd0, select_X1, select_Y1, select_X2, select_Y2}, 64'd0);
    check("rst_res", {select_res_q, select_res_r}, 64'd0);
    select_rst = 1'b1;
    #1;
    check("rel_rdy", 64'(select_pt_ready), 64'd1);
    @(posedge clk); #1;

    // 1: exact match on centroid 2.
    cx = '{10, 200, 47, 0};   cy = '{35, 200, 54, 0};
    load_cents(cx, cy);
    run_point("t1", 47, 54, 0, 0, 0, 0, 0, 0);

    // 2: equal Q, R decides.
    cx = '{100, 6, 6, 300};   cy = '{100, 0, 1, 300};
    load_cents(cx, cy);
    run_point("t2", 0, 0, 0, 0, 0, 0, 0, 0);

    // 3: exact tie, lowest index wins; 4: backpressure for 5 cycles.
    cx = '{0, 500, 600, 10};  cy = '{0, 500, 600, 10};
    load_cents(cx, cy);
    run_point("t3", 5, 5, 5, 0, 0, 0, 0, 0);

    // 5: writes while busy are dropped; then a same-cycle write at accept lands.
    cx = '{10, 200, 47, 0};   cy = '{35, 200, 54, 0};
    load_cents(cx, cy);
    run_point("t5", 47, 54, 1, 0, 1, 2, 1023, 1023);
    run_point("t5_rep", 47, 54, 0, 0, 0, 0, 0, 0);
    run_point("t5_acc", 900, 900, 0, 1, 0, 3, 901, 899);

    // 6: reset mid-ISSUE.
    load_cents(cx, cy);
    select_pt_x = CW'(47);
    select_pt_y = CW'(54);
    select_pt_valid = 1'b1;
    @(posedge clk); #1;
    select_pt_valid = 1'b0;
    @(posedge clk); #1;
    select_rst = 1'b0;
    #1;
    check("t6_rdy", 64'(select_pt_ready), 64'd0);
    check("t6_valid", 64'(select_res_valid), 64'd0);
    check("t6_xy", {16'd0, select_X1, select_Y1, select_X2, select_Y2}, 64'd0);
    check("t6_res", {30'd0, select_res_idx, select_res_q}, 64'd0);
    check("t6_res_r", 64'(select_res_r), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_hold_valid", 64'(select_res_valid), 64'd0);
    end
    select_rst = 1'b1;
    for (int i = 0; i < K; i++) begin
      mcx[i] = 0;
      mcy[i] = 0;
    end
    repeat (8) begin
      @(posedge clk); #1;
      check("t6_no_stale", {63'd0, select_res_valid}, 64'd0);
    end
    run_point("t6_zero_tab", 3, 4, 0, 0, 0, 0, 0, 0);
    load_cents(cx, cy);
    run_point("t6_reload", 47, 54, 0, 0, 0, 0, 0, 0);

    // Randomized tables and points, with forced duplicates for ties.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < K; i++) begin
        cx[i] = int'($urandom_range(1023, 0));
        cy[i] = int'($urandom_range(1023, 0));
      end
      if ($urandom_range(3, 0) == 0) begin
        cx[3] = cx[1];
        cy[3] = cy[1];
      end
      load_cents(cx, cy);
      run_point("rnd", int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                int'($urandom_range(3, 0)), 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
